// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state codes and next-PC select codes for fetch_addr_unit
package fetch_pkg;
  localparam int PC_W_DEF = 9;
  localparam int OFF_W_DEF = 8;
  typedef logic [2:0] state_t;
  localparam state_t S_FETCH = 3'd0;
  localparam state_t S_WAIT = 3'd1;
  localparam state_t S_LOAD = 3'd2;
  localparam state_t S_EXEC = 3'd3;
  localparam state_t S_HALT = 3'd4;
  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_INC = 2'd1;
  localparam logic [1:0] SEL_REL = 2'd2;
  localparam logic [1:0] SEL_ABS = 2'd3;
endpackage

// File: rtl/fetch_addr_unit_if.sv
// fetch_addr_unit_if: controller/RAM-side bus of fetch_addr_unit; slave = the unit, master = controller; BREAKPOINT_EN adds bkpt_en/bkpt_addr/bkpt_hit
interface fetch_addr_unit_if import fetch_pkg::*; #(parameter int PC_W = PC_W_DEF, parameter int OFF_W = OFF_W_DEF);
  logic exec_done, br_take, br_mode, halt_req, resume, dat_req, dat_we;
  logic [OFF_W-1:0] br_imm;
  logic [PC_W-1:0] br_target, dat_addr, mem_addr, pc;
  logic mem_rd, mem_wr, ir_load, exec_start, halted;
`ifdef BREAKPOINT_EN
  logic bkpt_en, bkpt_hit;
  logic [PC_W-1:0] bkpt_addr;
`endif
  modport master(
    output exec_done, br_take, br_mode, br_imm, br_target, halt_req, resume, dat_req, dat_addr, dat_we,
    input mem_addr, mem_rd, mem_wr, ir_load, exec_start, pc, halted
`ifdef BREAKPOINT_EN
    , output bkpt_en, bkpt_addr, input bkpt_hit
`endif
  );
  modport slave(
    input exec_done, br_take, br_mode, br_imm, br_target, halt_req, resume, dat_req, dat_addr, dat_we,
    output mem_addr, mem_rd, mem_wr, ir_load, exec_start, pc, halted
`ifdef BREAKPOINT_EN
    , input bkpt_en, bkpt_addr, output bkpt_hit
`endif
  );
endinterface

// File: rtl/fetch_addr_unit_pc_next_calc.sv
// pc_next_calc: combinational next PC (hold, +1, +sext(imm), absolute) modulo 2^PC_W; ports i_sel, i_pc, i_imm, i_target -> o_next
module pc_next_calc import fetch_pkg::*; #(parameter int PC_W = PC_W_DEF, parameter int OFF_W = OFF_W_DEF) (
  input  logic [1:0]       i_sel,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [OFF_W-1:0] i_imm,
  input  logic [PC_W-1:0]  i_target,
  output logic [PC_W-1:0]  o_next
);
  logic [PC_W-1:0] w_sext;
  assign w_sext = PC_W'($signed(i_imm));
  assign o_next = (i_sel == SEL_INC) ? i_pc + PC_W'(1) :
                  (i_sel == SEL_REL) ? i_pc + w_sext :
                  (i_sel == SEL_ABS) ? i_target : i_pc;
endmodule

// File: rtl/fetch_addr_unit.sv
// fetch_addr_unit: PC owner and fetch sequencer (FETCH/WAIT/LOAD/EXEC/HALT); ports clk, reset, bus (fetch_addr_unit_if.slave); optional BREAKPOINT_EN
module fetch_addr_unit import fetch_pkg::*; #(
  parameter int PC_W = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input logic clk,
  input logic reset,
  fetch_addr_unit_if.slave bus
);
  state_t r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic r_exec_start;
  logic [1:0] w_sel;
  logic w_exec, w_done, w_bkpt, w_dat;
`ifdef BREAKPOINT_EN
  logic r_skip, r_bkpt_hit, w_resume;
  assign w_resume = (r_state == S_HALT) && bus.resume;
  assign w_bkpt = (r_state == S_FETCH) && bus.bkpt_en && (r_pc == bus.bkpt_addr) && !r_skip;
  assign bus.bkpt_hit = r_bkpt_hit;
  // skip lets the breakpointed address fetch once after resume, then re-arms at S_LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skip <= 1'b0;
      r_bkpt_hit <= 1'b0;
    end else begin
      r_bkpt_hit <= w_bkpt || (r_bkpt_hit && !w_resume);
      r_skip <= (w_resume && r_bkpt_hit) || (r_skip && r_state != S_LOAD);
    end
  end
`else
  assign w_bkpt = 1'b0;
`endif
  assign w_exec = r_state == S_EXEC;
  assign w_done = w_exec && bus.exec_done;
  assign w_dat = w_exec && bus.dat_req;
  assign w_sel = (r_state == S_LOAD) ? SEL_INC :
                 (w_done && !bus.halt_req && bus.br_take) ? (bus.br_mode ? SEL_ABS : SEL_REL) : SEL_HOLD;
  assign w_state_next = (r_state == S_FETCH) ? (w_bkpt ? S_HALT : S_WAIT) :
                        (r_state == S_WAIT) ? S_LOAD :
                        (r_state == S_LOAD) ? S_EXEC :
                        w_exec ? (w_done ? (bus.halt_req ? S_HALT : S_FETCH) : S_EXEC) :
                        (bus.resume ? S_FETCH : S_HALT);
  pc_next_calc #(.PC_W(PC_W), .OFF_W(OFF_W)) u_next (
    .i_sel(w_sel), .i_pc(r_pc), .i_imm(bus.br_imm), .i_target(bus.br_target), .o_next(w_pc_next)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc <= RESET_VEC;
      r_exec_start <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc <= w_pc_next;
      r_exec_start <= r_state == S_LOAD;
    end
  end
  // strobes are forced low while reset is asserted so an aborted access never reaches the RAM
  assign bus.mem_addr = w_dat ? bus.dat_addr : r_pc;
  assign bus.mem_rd = !reset && (((r_state == S_FETCH) && !w_bkpt) || (r_state == S_WAIT) || (w_dat && !bus.dat_we));
  assign bus.mem_wr = !reset && w_dat && bus.dat_we;
  assign bus.ir_load = !reset && (r_state == S_LOAD);
  assign bus.exec_start = !reset && r_exec_start;
  assign bus.pc = r_pc;
  assign bus.halted = r_state == S_HALT;
endmodule

// File: tb/tb_fetch_addr_unit.sv
// tb_fetch_addr_unit: directed literal checks plus randomized run against an instruction-level model
module tb_fetch_addr_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int m_valid = 0;
  int m_pc = 0;
  int m_cnt = 0;
  int m_halt = 0;
  fetch_addr_unit_if #(.PC_W(9), .OFF_W(8)) bif();
  fetch_addr_unit #(.PC_W(9), .OFF_W(8), .RESET_VEC(9'd0)) dut(.clk(clk), .reset(reset), .bus(bif.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic idle();
    bif.exec_done = 0; bif.br_take = 0; bif.br_mode = 0; bif.br_imm = '0; bif.br_target = '0;
    bif.halt_req = 0; bif.resume = 0; bif.dat_req = 0; bif.dat_addr = '0; bif.dat_we = 0;
`ifdef BREAKPOINT_EN
    bif.bkpt_en = 0; bif.bkpt_addr = '0;
`endif
  endtask
  task automatic wait_exec();
    int n = 0;
    while (bif.exec_start !== 1'b1 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_exec_in_time", int'(n < 12), 1);
  endtask
  task automatic branch(input logic mode, input logic [7:0] imm, input logic [8:0] tgt);
    bif.exec_done = 1; bif.br_take = 1; bif.br_mode = mode; bif.br_imm = imm; bif.br_target = tgt;
    @(posedge clk); #1;
    idle();
  endtask
  // instruction-level model: m_cnt counts cycles since the instruction's fetch began
  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1; m_pc <= 0; m_cnt <= 0; m_halt <= 0;
    end else if (m_valid != 0) begin
      if (m_halt != 0) begin
        if (bif.resume) begin m_halt <= 0; m_cnt <= 0; end
      end else if (m_cnt == 2) begin
        m_pc <= (m_pc + 1) % 512; m_cnt <= 3;
      end else if (m_cnt >= 3) begin
        if (bif.exec_done) begin
          m_cnt <= 0;
          if (bif.halt_req) m_halt <= 1;
          else if (bif.br_take) m_pc <= bif.br_mode ? int'(bif.br_target) : (m_pc + int'($signed(bif.br_imm))) & 511;
        end else m_cnt <= 4;
      end else m_cnt <= m_cnt + 1;
    end
  end
  always @(negedge clk) begin
    if (m_valid != 0) begin
      chk("pc", int'(bif.pc), m_pc);
      if (reset) begin
        chk("reset_strobes", int'({bif.mem_rd, bif.mem_wr, bif.ir_load, bif.exec_start}), 0);
      end else begin
        chk("halted", int'(bif.halted), m_halt);
        chk("ir_load", int'(bif.ir_load), int'(m_halt == 0 && m_cnt == 2));
        chk("exec_start", int'(bif.exec_start), int'(m_halt == 0 && m_cnt == 3));
        if (m_halt != 0) chk("halt_rdwr", int'({bif.mem_rd, bif.mem_wr}), 0);
        else if (m_cnt < 2) begin
          chk("fetch_addr", int'(bif.mem_addr), m_pc);
          chk("fetch_rd", int'(bif.mem_rd), 1);
          chk("fetch_wr", int'(bif.mem_wr), 0);
        end else if (m_cnt == 2) chk("load_wr", int'(bif.mem_wr), 0);
        else begin
          chk("exec_addr", int'(bif.mem_addr), bif.dat_req ? int'(bif.dat_addr) : m_pc);
          chk("exec_rd", int'(bif.mem_rd), int'(bif.dat_req && !bif.dat_we));
          chk("exec_wr", int'(bif.mem_wr), int'(bif.dat_req && bif.dat_we));
        end
      end
    end
  end
  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("t1_c1_addr", int'(bif.mem_addr), 0);
    chk("t1_c1_rd", int'(bif.mem_rd), 1);
    @(posedge clk); #1;
    chk("t1_c2_rd", int'(bif.mem_rd), 1);
    @(posedge clk); #1;
    chk("t1_c3_ir_load", int'(bif.ir_load), 1);
    @(posedge clk); #1;
    chk("t1_c4_exec_start", int'(bif.exec_start), 1);
    chk("t1_c4_pc", int'(bif.pc), 1);
    branch(1'b1, 8'd0, 9'd4);
    chk("t2_abs4_addr", int'(bif.mem_addr), 4);
    wait_exec();
    chk("t2_pc5", int'(bif.pc), 5);
    branch(1'b0, 8'hFD, 9'd0);
    chk("t2_rel_minus3", int'(bif.mem_addr), 2);
    wait_exec();
    branch(1'b1, 8'd0, 9'd510);
    wait_exec();
    chk("t2_pc511", int'(bif.pc), 511);
    branch(1'b0, 8'd1, 9'd0);
    chk("t2_wrap0", int'(bif.mem_addr), 0);
    wait_exec();
    branch(1'b1, 8'd0, 9'h1A0);
    chk("t3_abs_1a0", int'(bif.mem_addr), 'h1A0);
    wait_exec();
    bif.dat_req = 1; bif.dat_we = 1; bif.dat_addr = 9'h40;
    #1;
    chk("t4_exec_addr", int'(bif.mem_addr), 'h40);
    chk("t4_exec_wr", int'(bif.mem_wr), 1);
    chk("t4_exec_rd", int'(bif.mem_rd), 0);
    bif.exec_done = 1;
    @(posedge clk); #1;
    bif.exec_done = 0;
    #1;
    chk("t4_fetch_wr", int'(bif.mem_wr), 0);
    chk("t4_fetch_addr", int'(bif.mem_addr), 'h1A1);
    idle();
    wait_exec();
    chk("t5_pc", int'(bif.pc), 'h1A2);
    bif.exec_done = 1; bif.halt_req = 1; bif.br_take = 1; bif.br_mode = 1; bif.br_target = 9'd7;
    @(posedge clk); #1;
    chk("t5_halted", int'(bif.halted), 1);
    chk("t5_pc_held", int'(bif.pc), 'h1A2);
    chk("t5_no_rd", int'(bif.mem_rd), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_still_halted", int'(bif.halted), 1);
    chk("t5_pc_still", int'(bif.pc), 'h1A2);
    idle();
    bif.resume = 1;
    @(posedge clk); #1;
    idle();
    chk("t5_resumed", int'(bif.halted), 0);
    chk("t5_refetch_addr", int'(bif.mem_addr), 'h1A2);
    chk("t5_refetch_rd", int'(bif.mem_rd), 1);
    repeat (3000) begin
      @(posedge clk); #1;
      reset = $urandom_range(0, 199) == 0;
      bif.exec_done = $urandom_range(0, 2) == 0;
      bif.br_take = $urandom_range(0, 1) == 1;
      bif.br_mode = $urandom_range(0, 1) == 1;
      bif.br_imm = 8'($urandom);
      bif.br_target = 9'($urandom);
      bif.halt_req = $urandom_range(0, 7) == 0;
      bif.resume = $urandom_range(0, 3) == 0;
      bif.dat_req = $urandom_range(0, 1) == 1;
      bif.dat_we = $urandom_range(0, 1) == 1;
      bif.dat_addr = 9'($urandom);
    end
    @(posedge clk); #1;
    reset = 0;
    idle();
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
